// File: rtl/srl_tap_sequencer.sv
// ----------------------------------------------------------------------------
// srl_tap_sequencer
//
// Drives a 16-stage x 32-bit addressable shift register (srl16x32e) used as
// the tap delay line of a decimating FIR filter.
//
// Samples are shifted into the delay line through a valid/ready handshake.
// After every DECIM accepted samples, the block sweeps the tap address
// across taps 0..NTAPS-1. Each tap is presented to a downstream MAC with
// first/last framing, and the MAC can apply backpressure. The delay line is
// frozen for the whole sweep, so every tap of one sweep comes from the same
// sample history.
//
// Parameters
//   NTAPS          number of taps swept (1..16)
//   DECIM          accepted samples per sweep (1..255)
//
// Ports
//   clk            rising-edge clock
//   rstn           asynchronous active-low reset
//   in_valid       source presents a sample on the srl16x32e d bus
//   in_ready       sequencer can accept a sample this cycle
//   srl_ce         srl16x32e shift enable (in_valid & in_ready)
//   srl_a          registered tap address to srl16x32e
//   tap_valid      srl_a holds a live tap this cycle
//   tap_first      current tap is tap 0 (MAC clears its accumulator)
//   tap_last       current tap is tap NTAPS-1
//   mac_ready      MAC consumes the current tap on this edge
//   result_strobe  one-cycle pulse: the MAC result of the last sweep is final
//   busy           a sweep is in progress
// ----------------------------------------------------------------------------
module srl_tap_sequencer #(
    parameter int NTAPS = 16,
    parameter int DECIM = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       srl_ce,
    output logic [3:0] srl_a,
    output logic       tap_valid,
    output logic       tap_first,
    output logic       tap_last,
    input  logic       mac_ready,
    output logic       result_strobe,
    output logic       busy
);

    localparam logic [3:0] LAST_TAP   = 4'(NTAPS - 1);
    localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

    typedef enum logic {
        FILL  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] scnt_q, scnt_d;
    logic [3:0] srl_a_q, srl_a_d;
    logic       tap_valid_q, tap_valid_d;
    logic       tap_first_q, tap_first_d;
    logic       tap_last_q, tap_last_d;
    logic       result_strobe_q, result_strobe_d;
    logic       accept;

    // The handshake is purely combinational from the state, so a shift can
    // never happen while a sweep is reading the delay line.
    assign in_ready = (state_q == FILL);
    assign accept   = in_valid & in_ready;
    assign srl_ce   = accept;
    assign busy     = (state_q == SWEEP);

    assign srl_a         = srl_a_q;
    assign tap_valid     = tap_valid_q;
    assign tap_first     = tap_first_q;
    assign tap_last      = tap_last_q;
    assign result_strobe = result_strobe_q;

    // Next-state logic. All tap outputs are computed one cycle ahead so that
    // they leave the block straight from flops. In FILL the tap outputs stay
    // at zero because they are cleared on every exit from SWEEP.
    always_comb begin
        state_d         = state_q;
        scnt_d          = scnt_q;
        srl_a_d         = srl_a_q;
        tap_valid_d     = tap_valid_q;
        tap_first_d     = tap_first_q;
        tap_last_d      = tap_last_q;
        result_strobe_d = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (scnt_q == DECIM_LAST) begin
                        scnt_d      = 8'd0;
                        state_d     = SWEEP;
                        srl_a_d     = 4'd0;
                        tap_valid_d = 1'b1;
                        tap_first_d = 1'b1;
                        // A single-tap filter starts and ends on the same tap.
                        tap_last_d  = (LAST_TAP == 4'd0);
                    end else begin
                        scnt_d = scnt_q + 8'd1;
                    end
                end
            end

            SWEEP: begin
                if (mac_ready) begin
                    if (tap_last_q) begin
                        state_d         = FILL;
                        srl_a_d         = 4'd0;
                        tap_valid_d     = 1'b0;
                        tap_first_d     = 1'b0;
                        tap_last_d      = 1'b0;
                        result_strobe_d = 1'b1;
                    end else begin
                        srl_a_d     = srl_a_q + 4'd1;
                        tap_first_d = 1'b0;
                        tap_last_d  = ((srl_a_q + 4'd1) == LAST_TAP);
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Reset drops straight back to FILL. A sweep that is cut short by reset
    // never produces a result strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= FILL;
            scnt_q          <= 8'd0;
            srl_a_q         <= 4'd0;
            tap_valid_q     <= 1'b0;
            tap_first_q     <= 1'b0;
            tap_last_q      <= 1'b0;
            result_strobe_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            scnt_q          <= scnt_d;
            srl_a_q         <= srl_a_d;
            tap_valid_q     <= tap_valid_d;
            tap_first_q     <= tap_first_d;
            tap_last_q      <= tap_last_d;
            result_strobe_q <= result_strobe_d;
        end
    end

endmodule

// File: tb/tb_srl_tap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_srl_tap_sequencer
//
// Two sequencers share one source and one MAC-ready signal:
//   instance 0: NTAPS=16, DECIM=4
//   instance 1: NTAPS=1,  DECIM=2
//
// Each instance drives its own behavioural srl16x32e. Outputs are compared
// every cycle against a sample-history reference model. For each tap, the
// model expects the value of the sample accepted k samples before the
// newest one at the start of the sweep.
// ----------------------------------------------------------------------------
module tb_srl_tap_sequencer;

    localparam int NT [2] = '{16, 1};
    localparam int DC [2] = '{4, 2};

    logic            clk = 1'b0;
    logic            rstn;
    logic            in_valid;
    logic            mac_ready;
    logic [31:0]     din;

    logic [1:0]      in_ready;
    logic [1:0]      srl_ce;
    logic [1:0][3:0] srl_a;
    logic [1:0]      tap_valid;
    logic [1:0]      tap_first;
    logic [1:0]      tap_last;
    logic [1:0]      result_strobe;
    logic [1:0]      busy;

    srl_tap_sequencer #(.NTAPS(16), .DECIM(4)) dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready[0]),
        .srl_ce(srl_ce[0]), .srl_a(srl_a[0]), .tap_valid(tap_valid[0]),
        .tap_first(tap_first[0]), .tap_last(tap_last[0]), .mac_ready(mac_ready),
        .result_strobe(result_strobe[0]), .busy(busy[0])
    );

    srl_tap_sequencer #(.NTAPS(1), .DECIM(2)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready[1]),
        .srl_ce(srl_ce[1]), .srl_a(srl_a[1]), .tap_valid(tap_valid[1]),
        .tap_first(tap_first[1]), .tap_last(tap_last[1]), .mac_ready(mac_ready),
        .result_strobe(result_strobe[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    // Behavioural srl16x32e per instance. INIT is zero, and reset does not
    // clear the contents.
    logic [31:0] mem [2][16];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (srl_ce[i]) begin
                mem[i][0] <= din;
                for (int k = 1; k < 16; k++) mem[i][k] <= mem[i][k-1];
            end
        end
    end

    // Reference model. acc keeps the last 16 accepted samples, newest first.
    // A reset does not clear acc because the delay line is never cleared.
    logic [31:0] acc  [2][16];
    logic [31:0] snap [2][16];
    bit          m_busy   [2];
    int          m_tap    [2];
    int          m_cnt    [2];
    bit          m_strobe [2];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit period_check = 1'b0;
    int last_str [2];
    int n_str    [2];

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h",
                     tag, cyc, got, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i]   = 1'b0;
            m_tap[i]    = 0;
            m_cnt[i]    = 0;
            m_strobe[i] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge, using the inputs seen on that edge.
    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            m_strobe[i] = 1'b0;
            if (!m_busy[i]) begin
                if (in_valid) begin
                    for (int k = 15; k > 0; k--) acc[i][k] = acc[i][k-1];
                    acc[i][0] = din;
                    m_cnt[i]++;
                    if (m_cnt[i] == DC[i]) begin
                        m_cnt[i]  = 0;
                        m_busy[i] = 1'b1;
                        m_tap[i]  = 0;
                        for (int k = 0; k < 16; k++) snap[i][k] = acc[i][k];
                    end
                end
            end else if (mac_ready) begin
                if (m_tap[i] == NT[i] - 1) begin
                    m_busy[i]   = 1'b0;
                    m_strobe[i] = 1'b1;
                end else begin
                    m_tap[i]++;
                end
            end
        end
    endtask

    // Compare every output of both instances with the model for this cycle.
    task automatic checkCycle();
        for (int i = 0; i < 2; i++) begin
            string p;
            p = $sformatf("i%0d", i);
            checkOutput({p, " in_ready"},  32'(in_ready[i]),  32'(!m_busy[i]));
            checkOutput({p, " srl_ce"},    32'(srl_ce[i]),    32'(in_valid & !m_busy[i]));
            checkOutput({p, " busy"},      32'(busy[i]),      32'(m_busy[i]));
            checkOutput({p, " tap_valid"}, 32'(tap_valid[i]), 32'(m_busy[i]));
            checkOutput({p, " srl_a"},     32'(srl_a[i]),     m_busy[i] ? 32'(m_tap[i]) : 32'd0);
            checkOutput({p, " tap_first"}, 32'(tap_first[i]), 32'(m_busy[i] && m_tap[i] == 0));
            checkOutput({p, " tap_last"},  32'(tap_last[i]),  32'(m_busy[i] && m_tap[i] == NT[i] - 1));
            checkOutput({p, " result_strobe"}, 32'(result_strobe[i]), 32'(m_strobe[i]));
            if (m_busy[i])
                checkOutput({p, " tap_data"}, mem[i][srl_a[i]], snap[i][m_tap[i]]);
        end
    endtask

    // Drive one cycle: new inputs just after the rising edge, check on the
    // falling edge, then step the model on the next rising edge.
    task automatic applyStimulus(input bit iv, input bit mr);
        in_valid  = iv;
        mac_ready = mr;
        din       = $urandom;
        @(negedge clk);
        checkCycle();
        if (period_check) begin
            for (int i = 0; i < 2; i++) begin
                if (result_strobe[i]) begin
                    if (n_str[i] > 0)
                        checkOutput($sformatf("i%0d output period", i),
                                    32'(cyc - last_str[i]), 32'(NT[i] + DC[i]));
                    last_str[i] = cyc;
                    n_str[i]++;
                end
            end
        end
        @(posedge clk);
        modelStep();
        cyc++;
        #1;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) begin
                mem[i][k]  = 32'd0;
                acc[i][k]  = 32'd0;
                snap[i][k] = 32'd0;
            end
            last_str[i] = 0;
            n_str[i]    = 0;
        end
        modelReset();
        rstn      = 1'b0;
        in_valid  = 1'b1;
        mac_ready = 1'b0;
        din       = 32'd0;
        #3;
        checkCycle();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        modelStep();
        cyc++;
        #1;

        // Random valid and MAC backpressure.
        for (int n = 0; n < 600; n++)
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);

        // Drive instance 0 to tap 7, then pull reset between clock edges.
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            if (m_busy[0] && m_tap[0] == 7) found = 1'b1;
            else applyStimulus(1'b1, $urandom_range(0, 1) == 1);
        end
        checkOutput("reach tap 7 before reset", 32'(found), 32'd1);
        if (found) begin
            in_valid = 1'b1;
            #2;
            checkOutput("i0 srl_a before reset", 32'(srl_a[0]), 32'd7);
            rstn = 1'b0;
            #1;
            modelReset();
            checkCycle();
            @(negedge clk);
            rstn = 1'b1;
            @(posedge clk);
            modelStep();
            cyc++;
            #1;
        end

        // Continuous input with the MAC always ready: fixed output period.
        period_check = 1'b1;
        for (int n = 0; n < 120; n++) applyStimulus(1'b1, 1'b1);
        period_check = 1'b0;
        checkOutput("i0 strobes seen", 32'(n_str[0] >= 3), 32'd1);
        checkOutput("i1 strobes seen", 32'(n_str[1] >= 3), 32'd1);

        // Input held high during sweeps with heavy MAC backpressure.
        for (int n = 0; n < 400; n++) applyStimulus(1'b1, $urandom_range(0, 1) == 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/srl_tap_sequencer.md
# srl_tap_sequencer

Sequencer for the 16-stage × 32-bit addressable shift register (srl16x32e) used as a FIR tap delay line. It accepts input samples through a valid/ready handshake and shifts them into the delay line via `srl_ce`. After every DECIM accepted samples it sweeps `srl_a` across taps 0..NTAPS-1 and presents each tap to a downstream multiply-accumulate unit, with first/last framing and backpressure. It sits between the sample source and the srl16x32e/MAC pair in the decimating filter chain.

## Interface
- NTAPS, 16, number of taps swept; legal range 1..16.
- DECIM, 1, accepted samples per sweep (decimation ratio); legal range 1..255.

- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  source has a sample on the srl16x32e `d` bus.
- in_ready  out  1  sequencer can accept a sample this cycle.
- srl_ce  out  1  shift enable to srl16x32e `ce`; equals `in_valid & in_ready` (combinational).
- srl_a  out  4  tap address to srl16x32e `a`; registered.
- tap_valid  out  1  `srl_a` holds a live tap, so srl16x32e `y` is valid this cycle; registered.
- tap_first  out  1  current tap is tap 0 (MAC clears its accumulator); registered.
- tap_last  out  1  current tap is tap NTAPS-1; registered.
- mac_ready  in  1  MAC consumes the current tap on this edge.
- result_strobe  out  1  one-cycle pulse: the MAC result for the completed sweep is final; registered.
- busy  out  1  sweep in progress; equals state==SWEEP.

## Operation
- State machine with two states, FILL and SWEEP. Reset state is FILL.
- **FILL**
  - `in_ready`=1, `tap_valid`=0, `srl_a`=0.
  - Each accepted sample (`in_valid & in_ready`) increments an 8-bit sample counter `scnt`.
  - When a sample is accepted with `scnt`==DECIM-1: clear `scnt`, go to SWEEP, load tap index 0.
- **SWEEP**
  - `in_ready`=0, so `srl_ce` cannot assert. The delay line must never shift mid-sweep.
  - `tap_valid`=1 and `srl_a` = tap index.
  - `tap_first` = (index==0); `tap_last` = (index==NTAPS-1).
  - If `mac_ready`=1 and not last: index increments.
  - If `mac_ready`=1 and last: go to FILL and set `result_strobe` for the next cycle.
  - If `mac_ready`=0: `srl_a`, `tap_valid`, `tap_first` and `tap_last` all hold.
- Tap k addresses the sample accepted k samples before the most recent one (tap 0 = newest).
- NTAPS=1: the single sweep cycle has both `tap_first` and `tap_last` set.
- `in_valid` is ignored in SWEEP. The source must hold its data until `in_ready` returns.
- srl16x32e contents are not cleared by this block. Samples shifted before the first full history are whatever the SRL held (INIT=0 after configuration).
- Reset values, with `rstn`=0 taking effect immediately (asynchronous):
  - `in_ready`=1
  - `srl_ce` = `in_valid`
  - `srl_a`=0, `tap_valid`=0, `tap_first`=0, `tap_last`=0
  - `result_strobe`=0, `busy`=0
  - `scnt`=0, state FILL
- Reset mid-sweep abandons the sweep; no `result_strobe` is issued for it.

## Timing
- Sample accepted at edge E that completes a decimation group: the cycle after E is the first SWEEP cycle, with `srl_a`=0 and `tap_first`=1.
- With `mac_ready` held high, a sweep lasts exactly NTAPS cycles.
- `result_strobe` is high in the first FILL cycle after the sweep. `in_ready` is also high in that cycle.
- Minimum period per output: DECIM + NTAPS cycles.
- Each low cycle of `mac_ready` during SWEEP adds exactly one cycle.
- `srl_ce` has zero latency from `in_valid` in FILL.
- `y` is combinational from `srl_a`. The MAC samples `y` on the same edge that `mac_ready` is sampled.

## Test plan
1. **Reset values.** Drive `rstn` low during SWEEP at tap 7 → all outputs take reset values asynchronously, before the next edge. After release, DECIM fresh samples are needed before a sweep. No `result_strobe` appears.
2. **Basic sweep, ramp data.** NTAPS=16, DECIM=1, `mac_ready`=1, ramp data into a real srl16x32e, accept sample value 20 at cycle 0:
   - cycles 1..16: `srl_a`=0..15 and `y`=20,19,…,5
   - `tap_first` at cycle 1, `tap_last` at cycle 16
   - `result_strobe` and `in_ready` at cycle 17
3. **Decimation.** DECIM=4 with gapped `in_valid` → exactly 4 `srl_ce` pulses, then one 16-cycle sweep. `srl_ce` never asserts while `busy`=1.
4. **MAC backpressure.** `mac_ready` low for 3 cycles while `srl_a`=5 → `srl_a` holds 5 and `tap_valid` stays 1. The sweep takes 19 cycles and `result_strobe` is delayed by 3.
5. **Single tap.** NTAPS=1, DECIM=2 → one sweep cycle with `tap_first`=`tap_last`=1 and `srl_a`=0. Output period is 3 cycles with continuous input.
6. **Input blocked during sweep.** `in_valid` held high throughout → `in_ready`=0 for the whole sweep. The held sample is accepted in the `result_strobe` cycle, and tap ordering is preserved on the next sweep.
